// File: rtl/frog_key_pulser.sv
// Four-button conditioner: sync, debounce and one-cycle move pulses with fixed-priority serialization.
// Optional auto-repeat while a key is held is enabled by defining FROG_KEY_REPEAT_EN.
module frog_key_pulser #(
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 5000,
  parameter int REPEAT_PERIOD = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] held
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } key_state_t;

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES);

  if (DB_CYCLES < 2 || DB_CYCLES > 65535 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("frog_key_pulser: illegal parameter value");
  end

  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  pressed;
  key_state_t  state_q [4];
  key_state_t  state_d [4];
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic [3:0]  set_pend;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  grant;
  logic [3:0]  held_q, held_d;
  logic [3:0]  move_q, move_d;

`ifdef FROG_KEY_REPEAT_EN
  localparam logic [31:0] REP_DELAY  = 32'(REPEAT_DELAY);
  localparam logic [31:0] REP_PERIOD = 32'(REPEAT_PERIOD);

  logic [31:0] rep_q [4];
  logic [31:0] rep_d [4];
  logic [3:0]  rep_armed_q, rep_armed_d;
`endif

  assign pressed = ~sync2_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      set_pend[i] = 1'b0;
`ifdef FROG_KEY_REPEAT_EN
      rep_d[i]       = '0;
      rep_armed_d[i] = 1'b0;
`endif
      case (state_q[i])
        IDLE: begin
          if (pressed[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = 16'd1;
          end
        end
        PRESS_WAIT: begin
          if (!pressed[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i]  = HELD;
            cnt_d[i]    = '0;
            set_pend[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end
        end
        HELD: begin
          if (!pressed[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = 16'd1;
          end else begin
`ifdef FROG_KEY_REPEAT_EN
            // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
            if (rep_q[i] + 32'd1 == (rep_armed_q[i] ? REP_PERIOD : REP_DELAY)) begin
              set_pend[i]    = 1'b1;
              rep_d[i]       = '0;
              rep_armed_d[i] = 1'b1;
            end else begin
              rep_d[i]       = rep_q[i] + 32'd1;
              rep_armed_d[i] = rep_armed_q[i];
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (pressed[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Lowest set pending bit wins; a fresh set on the same cycle keeps the bit pending.
  always_comb begin
    grant  = pend_q & (~pend_q + 4'd1);
    pend_d = (pend_q & ~grant) | set_pend;
    move_d = grant;
    held_d = '0;
    for (int i = 0; i < 4; i++) begin
      held_d[i] = (state_d[i] == HELD) || (state_d[i] == RELEASE_WAIT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      pend_q  <= '0;
      held_q  <= '0;
      move_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      pend_q  <= pend_d;
      held_q  <= held_d;
      move_q  <= move_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef FROG_KEY_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_armed_q <= '0;
      for (int i = 0; i < 4; i++) begin
        rep_q[i] <= '0;
      end
    end else begin
      rep_armed_q <= rep_armed_d;
      for (int i = 0; i < 4; i++) begin
        rep_q[i] <= rep_d[i];
      end
    end
  end
`endif

  assign up    = move_q[0];
  assign down  = move_q[1];
  assign left  = move_q[2];
  assign right = move_q[3];
  assign held  = held_q;

endmodule

// File: tb/tb_frog_key_pulser.sv
// Directed bench for frog_key_pulser with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Edge 0 is the first rising edge that samples the new key pattern.
module tb_frog_key_pulser;

  logic       clk;
  logic       reset;
  logic [3:0] key_n;
  logic       up, down, left, right;
  logic [3:0] held;

  int testsRun    = 0;
  int testsFailed = 0;

`ifdef FROG_KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  frog_key_pulser #(
    .DB_CYCLES    (4),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .key_n(key_n),
    .up   (up),
    .down (down),
    .left (left),
    .right(right),
    .held (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] pattern);
    key_n = pattern;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkCycle(input string name, input int e, input logic [3:0] expMove, input logic [3:0] expHeld);
    checkOutput($sformatf("%s_move@e%0d", name, e), {right, left, down, up}, expMove);
    checkOutput($sformatf("%s_held@e%0d", name, e), held, expHeld);
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(4'b1111);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [3:0] expMove;
    logic [3:0] expHeld;

    reset = 1'b1;
    key_n = 4'b1111;
    tick();
    tick();
    checkCycle("reset", 0, 4'b0000, 4'b0000);
    reset = 1'b0;
    idleCycles(3);
    checkCycle("postreset", 0, 4'b0000, 4'b0000);

    // Clean press of up, released at edge 30.
    applyStimulus(4'b1110);
    for (int e = 0; e < 46; e++) begin
      if (e == 30) applyStimulus(4'b1111);
      tick();
      expMove = (e == 7 || (REP_EN && e == 27)) ? 4'b0001 : 4'b0000;
      expHeld = (e >= 6 && e < 36) ? 4'b0001 : 4'b0000;
      checkCycle("t1", e, expMove, expHeld);
    end
    idleCycles(4);

    // Short bounces on down never qualify.
    for (int e = 0; e < 20; e++) begin
      applyStimulus(((e < 3) || (e >= 6 && e < 8) || (e >= 11 && e < 13)) ? 4'b1101 : 4'b1111);
      tick();
      checkCycle("t2", e, 4'b0000, 4'b0000);
    end
    idleCycles(4);

    // All four keys at once serialize in priority order.
    applyStimulus(4'b0000);
    for (int e = 0; e < 20; e++) begin
      tick();
      case (e)
        7:       expMove = 4'b0001;
        8:       expMove = 4'b0010;
        9:       expMove = 4'b0100;
        10:      expMove = 4'b1000;
        default: expMove = 4'b0000;
      endcase
      checkCycle("t3", e, expMove, (e >= 6) ? 4'b1111 : 4'b0000);
    end
    idleCycles(12);
    checkCycle("t3_release", 0, 4'b0000, 4'b0000);

    // Reset in the middle of a left debounce aborts it.
    applyStimulus(4'b1011);
    for (int e = 0; e < 4; e++) begin
      tick();
      checkCycle("t4_pre", e, 4'b0000, 4'b0000);
    end
    reset = 1'b1;
    #1;
    checkCycle("t4_inreset", 0, 4'b0000, 4'b0000);
    tick();
    reset = 1'b0;
    checkCycle("t4_afterreset", 0, 4'b0000, 4'b0000);
    for (int e = 0; e < 14; e++) begin
      tick();
      checkCycle("t4", e, (e == 7) ? 4'b0100 : 4'b0000, (e >= 6) ? 4'b0100 : 4'b0000);
    end
    idleCycles(12);

    // Right held with a 2-cycle release glitch while in HELD.
    applyStimulus(4'b0111);
    for (int e = 0; e < 31; e++) begin
      if (e == 10) applyStimulus(4'b1111);
      if (e == 12) applyStimulus(4'b0111);
      tick();
      checkCycle("t5", e, (e == 7) ? 4'b1000 : 4'b0000, (e >= 6) ? 4'b1000 : 4'b0000);
    end
    idleCycles(12);

    // Long hold of up: auto-repeat only when the feature is built in.
    applyStimulus(4'b1110);
    for (int e = 0; e < 61; e++) begin
      tick();
      if (e == 7)
        expMove = 4'b0001;
      else if (REP_EN && (e == 27 || e == 35 || e == 43 || e == 51 || e == 59))
        expMove = 4'b0001;
      else
        expMove = 4'b0000;
      checkCycle("t6", e, expMove, (e >= 6) ? 4'b0001 : 4'b0000);
    end
    idleCycles(12);
    checkCycle("final", 0, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/frog_key_pulser.md
# frog_key_pulser

Input conditioner that produces the single-cycle move pulses consumed by the frog position logic and the score counter. It takes the four raw, active-low push-button inputs, synchronizes and debounces each one, and converts each qualified press into exactly one clock-wide pulse on `up`, `down`, `left` or `right`. At most one pulse is emitted per cycle. Simultaneous presses are serialized by fixed priority, so no press is lost.

## Interface
- `DB_CYCLES`, default 16: consecutive stable synchronized samples required to accept a press or a release (legal range 2..65535).
- `REPEAT_DELAY`, default 5000: cycles in HELD before the first auto-repeat pulse (used only with the repeat feature).
- `REPEAT_PERIOD`, default 2000: cycles between subsequent auto-repeat pulses (used only with the repeat feature).

- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `key_n`  input  4  raw buttons, active-low, asynchronous to `clk`; bit0 = up, bit1 = down, bit2 = left, bit3 = right.
- `up`  output  1  one-cycle move pulse.
- `down`  output  1  one-cycle move pulse.
- `left`  output  1  one-cycle move pulse.
- `right`  output  1  one-cycle move pulse.
- `held`  output  4  debounced pressed level per key; 1 in HELD or RELEASE_WAIT.

## Operation
- **Synchronizer.** Each `key_n` bit passes through a 2-flop synchronizer that resets to 1 (released). `pressed = ~sync2`.
- **Per-key FSM** (4 independent copies), each with a 16-bit stable counter `cnt`:
  - IDLE: on pressed, go to PRESS_WAIT with `cnt = 1`.
  - PRESS_WAIT: on released, go to IDLE with `cnt = 0` (bounce rejected). On pressed, increment `cnt`. When `cnt` reaches `DB_CYCLES`, go to HELD, set `pend[i]`, and clear `cnt`.
  - HELD: on released, go to RELEASE_WAIT with `cnt = 1`.
  - RELEASE_WAIT: on pressed, return to HELD with no new pulse. On released, increment `cnt`. When `cnt` reaches `DB_CYCLES`, go to IDLE.
- **Pending flags** `pend[3:0]`:
  - `pend[i]` is set as described above.
  - It is held until granted, even if the key is released meanwhile.
  - It saturates: a second set while already pending is absorbed.
- **Arbiter.** Each cycle it grants the lowest-index set `pend` bit (up > down > left > right) and clears that bit. The granted pulse is registered, so the output asserts on the following edge. Ungranted bits wait.
- **Outputs.** The four move outputs are one-hot or zero in every cycle.
- **Reset.** Asserting `reset` at any time, including mid-debounce or with pulses pending, drops all outputs to 0 immediately. It also forces synchronizers to released, FSMs to IDLE, and `cnt` and `pend` to 0. No pulse is emitted for a press that was in progress at reset.
- **Reset values.** `up`, `down`, `left`, `right` = 0; `held` = 4'b0000.

## Timing
- For a clean press with no contention, the pulse is high for exactly one cycle, starting `DB_CYCLES + 3` rising edges after the first edge that samples `key_n[i]` low:
  - 2 edges of synchronizer;
  - `DB_CYCLES` edges to qualify;
  - 1 edge for the output register.
- `held[i]` rises on the same edge that `pend[i]` is set, one edge before the pulse.
- `held[i]` falls `DB_CYCLES + 2` edges after the first edge that samples the release.
- With contention, each additional pending key adds one cycle. Four simultaneous qualified presses produce pulses on four consecutive cycles in priority order.
- A glitch shorter than `DB_CYCLES` synchronized cycles never produces a pulse.

## Configuration
- `FROG_KEY_REPEAT_EN`:
  - **Defined:** HELD runs a repeat counter. It sets `pend[i]` after `REPEAT_DELAY` cycles in HELD, then every `REPEAT_PERIOD` cycles while the key stays in HELD. Entering RELEASE_WAIT stops and clears the repeat counter; returning to HELD restarts it from 0.
  - **Undefined:** no repeat counter is synthesized, and each press yields exactly one pulse however long it is held.

## Test plan
Run with `DB_CYCLES = 4`, `REPEAT_DELAY = 20`, `REPEAT_PERIOD = 8`.
1. Hold `key_n = 4'b1110` from edge 0 → `up` is high only at edge 7 and `held = 4'b0001` from edge 6; releasing at edge 30 → `held = 0` at edge 36; no further pulses.
2. Pulse `key_n[1]` low for 3 cycles, then high; repeat with 2-cycle bursts → `down` stays 0 throughout and `held[1]` stays 0.
3. Drive `key_n = 4'b0000` at edge 0 and hold → `up`, `down`, `left`, `right` each pulse once, at edges 7, 8, 9 and 10 respectively, never overlapping.
4. Press left and assert `reset` at edge 4 for 1 cycle, keeping the key held → no pulse from the aborted press; after reset deasserts, `left` pulses exactly `DB_CYCLES + 3` edges after the first post-reset sampling edge.
5. Press right, then while in HELD apply a 2-cycle release glitch → no second `right` pulse, and `held[3]` stays 1.
6. With `FROG_KEY_REPEAT_EN` defined, hold up for 60 cycles → `up` pulses at edges 7, 27, 35, 43, 51 and 59; without the macro, only at edge 7.
